// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM microphone controller.
//   pdm_state_e : controller state encoding
//   cnt_width() : counter width needed to hold 0..n-1 (never less than 1)
package pdm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } pdm_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pdm_clk_div.sv
// Microphone clock divider with single-cycle edge strobes.
//   clk     : system clock
//   reset_n : synchronous active-low reset
//   run     : divider enable; low holds the counter and mic_clk cleared
//   mic_clk : divided clock, period 2*HALF system cycles
//   rise    : one-cycle pulse coincident with mic_clk going 0->1
//   fall    : one-cycle pulse coincident with mic_clk going 1->0
module pdm_clk_div
    import pdm_pkg::*;
#(
    parameter int HALF = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic mic_clk,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(HALF);
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          mic_clk_q, mic_clk_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_comb begin
        cnt_d     = '0;
        mic_clk_d = 1'b0;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        if (run) begin
            mic_clk_d = mic_clk_q;
            if (cnt_q == CNT_LAST) begin
                cnt_d     = '0;
                mic_clk_d = ~mic_clk_q;
                // strobes are registered alongside mic_clk so they line up with its edges
                rise_d    = ~mic_clk_q;
                fall_d    = mic_clk_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            mic_clk_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mic_clk_q <= mic_clk_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    assign mic_clk = mic_clk_q;
    assign rise    = rise_q;
    assign fall    = fall_q;

endmodule

// File: rtl/pdm_mic_ctrl.sv
// PDM microphone capture controller: generates the mic clock, discards a
// warm-up interval, packs PDM bits MSB-first into words and offers them on
// an AXI-Stream master port.
//   clk, reset_n  : system clock, synchronous active-low reset
//   enable        : level request to run capture
//   mic_data      : PDM bit from the microphone
//   mic_clk       : microphone clock
//   m_axis_*      : packed word stream (tdata / tvalid / tready)
//   overflow      : sticky, set when a completed word had to be dropped
//   busy          : high whenever the controller is not idle
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | divider cleared, mic_clk low, waiting for enable
// ST_WARMUP  | mic clock running, counting rises, mic_data ignored
// ST_CAPTURE | shifting mic_data on each fall, emitting full words
// ST_DRAIN   | mic clock stopped, waiting for the pending word to be taken
module pdm_mic_ctrl
    import pdm_pkg::*;
#(
    parameter int INPUT_FREQ      = 100000000,
    parameter int OUTPUT_FREQ     = 2400000,
    parameter int WARMUP_MIC_CLKS = 24000,
    parameter int DATA_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  mic_data,
    output logic                  mic_clk,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  overflow,
    output logic                  busy
);

    localparam int CLK_DIVIDER = INPUT_FREQ / OUTPUT_FREQ;
    localparam int HALF        = CLK_DIVIDER / 2;   // must be at least 2
    localparam int WW          = cnt_width(WARMUP_MIC_CLKS);
    localparam int BW          = cnt_width(DATA_WIDTH);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_MIC_CLKS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    pdm_state_e            state_q, state_d;
    logic [WW-1:0]         warm_cnt_q, warm_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-2:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  overflow_q, overflow_d;
    logic                  busy_q, busy_d;

    logic                  div_run, div_rise, div_fall;
    logic                  hs, word_done;
    logic [DATA_WIDTH-1:0] word;

    // Running only while both the current and next state clock the mic:
    // entry from IDLE gets one extra cycle so the first rise lands HALF
    // cycles after WARMUP starts, and leaving stops mic_clk on the very next cycle.
    assign div_run = (state_q == ST_WARMUP || state_q == ST_CAPTURE) &&
                     (state_d == ST_WARMUP || state_d == ST_CAPTURE);

    pdm_clk_div #(.HALF(HALF)) u_clk_div (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (div_run),
        .mic_clk (mic_clk),
        .rise    (div_rise),
        .fall    (div_fall)
    );

    assign word = {shift_q, mic_data};
    assign hs   = tvalid_q && m_axis_tready;

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        overflow_d = overflow_q;
        word_done  = 1'b0;

        if (hs) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_WARMUP;
                    overflow_d = 1'b0;
                    warm_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            ST_WARMUP: begin
                if (!enable) begin
                    state_d    = ST_DRAIN;
                    warm_cnt_d = '0;
                end else if (div_rise) begin
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d    = ST_CAPTURE;
                        warm_cnt_d = '0;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                // stopping wins over a coincident fall: the partial word is dropped
                if (!enable) begin
                    state_d   = ST_DRAIN;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end else if (div_fall) begin
                    shift_d = word[DATA_WIDTH-2:0];
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        word_done = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!tvalid_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // the output slot is free if empty or being emptied this cycle
        if (word_done) begin
            if (!tvalid_q || hs) begin
                tdata_d  = word;
                tvalid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            warm_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign overflow      = overflow_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// Self-checking bench for pdm_mic_ctrl (HALF=4, 4 warm-up rises, 8-bit words).
// The reference model works at the level of mic clock edges, a bit list and
// a single-slot stream buffer.
module tb_pdm_mic_ctrl;

    localparam int DW   = 8;
    localparam int WARM = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          mic_data = 1'b0;
    logic          m_axis_tready = 1'b1;
    logic          mic_clk;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          overflow;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;
    int ncyc     = 0;

    // reference model: phase 0 idle, 1 running, 2 draining
    int            phase = 0;
    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_data = '0;
    logic          exp_ovf = 1'b0;
    logic [DW-1:0] m_word = '0;
    int            nbits = 0;
    bit            pend = 1'b0;
    int            rise_cnt = 0;
    logic          mclk_prev = 1'b0;
    int            mode = 0;          // 0: all ones, 1: alternating, 2: random
    logic          alt_next = 1'b1;
    logic          last_bit = 1'b1;

    pdm_mic_ctrl #(
        .INPUT_FREQ(8), .OUTPUT_FREQ(1), .WARMUP_MIC_CLKS(WARM), .DATA_WIDTH(DW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .mic_data      (mic_data),
        .mic_clk       (mic_clk),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock: apply the model's rules for the coming edge using
    // the inputs currently driven, then react to the new mic_clk level.
    task automatic cyc();
        logic          done;
        logic          hsk;
        logic [DW-1:0] w;
        done = 1'b0;
        w    = '0;
        hsk  = exp_valid && m_axis_tready;
        if (!reset_n) begin
            phase = 0; exp_valid = 1'b0; exp_data = '0; exp_ovf = 1'b0;
            nbits = 0; pend = 1'b0; rise_cnt = 0;
        end else begin
            if (phase == 1 && enable && pend) begin
                m_word = {m_word[DW-2:0], mic_data};
                nbits++;
                if (nbits == DW) begin
                    done = 1'b1; w = m_word; nbits = 0;
                end
            end
            pend = 1'b0;
            if (phase == 1 && !enable) begin
                phase = 2; nbits = 0;
            end else if (phase == 0 && enable) begin
                phase = 1; exp_ovf = 1'b0; nbits = 0; rise_cnt = 0;
            end else if (phase == 2 && !exp_valid) begin
                phase = 0;
            end
            if (done) begin
                if (!exp_valid || hsk) begin
                    exp_valid = 1'b1; exp_data = w;
                end else begin
                    exp_ovf = 1'b1;
                end
            end else if (hsk) begin
                exp_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        ncyc++;
        if (mclk_prev === 1'b0 && mic_clk === 1'b1) rise_cnt++;
        if (mclk_prev === 1'b1 && mic_clk === 1'b0 && phase == 1 && rise_cnt >= WARM) begin
            case (mode)
                0:       last_bit = 1'b1;
                1:       begin last_bit = alt_next; alt_next = ~alt_next; end
                default: last_bit = 1'($urandom_range(0, 1));
            endcase
            mic_data = last_bit;
            pend = 1'b1;
        end else begin
            // off-strobe cycles carry the opposite value so a mistimed sample shows up
            mic_data = (mode == 0) ? 1'b1 : ~last_bit;
        end
        mclk_prev = mic_clk;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; m_axis_tready = 1'b1;
        repeat (3) begin
            cyc();
            n_checks++;
            if ({mic_clk, m_axis_tvalid, m_axis_tdata, overflow, busy} !== '0)
                $display("FAIL reset_state @%0d: got mclk=%b valid=%b data=%h ovf=%b busy=%b, expected all 0",
                         ncyc, mic_clk, m_axis_tvalid, m_axis_tdata, overflow, busy);
            else n_pass++;
        end
        reset_n = 1'b1;
        cyc();
        n_checks++;
        if ({mic_clk, m_axis_tvalid, overflow, busy} !== '0)
            $display("FAIL idle_after_reset @%0d: got mclk=%b valid=%b ovf=%b busy=%b, expected all 0",
                     ncyc, mic_clk, m_axis_tvalid, overflow, busy);
        else n_pass++;
    endtask

    task automatic test_startup();
        int t;
        int t0;
        mode = 0; mic_data = 1'b1; m_axis_tready = 1'b1; enable = 1'b1;
        cyc();
        t0 = ncyc;
        n_checks++;
        if (busy !== 1'b1 || mic_clk !== 1'b0)
            $display("FAIL start_busy @%0d: got busy=%b mclk=%b, expected busy=1 mclk=0", ncyc, busy, mic_clk);
        else n_pass++;
        t = 0;
        while (mic_clk !== 1'b1 && t < 20) begin
            cyc(); t++;
        end
        n_checks++;
        if (t !== 4)
            $display("FAIL first_rise: got %0d cycles after busy, expected 4", t);
        else n_pass++;
        t = 0;
        while (m_axis_tvalid !== 1'b1 && t < 200) begin
            cyc(); t++;
            n_checks++;
            if ({m_axis_tvalid, m_axis_tdata, overflow, busy} !== {exp_valid, exp_data, exp_ovf, phase != 0}
                || (phase != 1 && mic_clk !== 1'b0))
                $display("FAIL startup_cycle @%0d: got valid=%b data=%h ovf=%b busy=%b, expected valid=%b data=%h ovf=%b busy=%b",
                         ncyc, m_axis_tvalid, m_axis_tdata, overflow, busy, exp_valid, exp_data, exp_ovf, phase != 0);
            else n_pass++;
        end
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || ncyc - t0 !== 89 || m_axis_tdata !== 8'hFF)
            $display("FAIL first_word: got valid=%b after %0d cycles data=%h, expected valid=1 after 89 data=ff",
                     m_axis_tvalid, ncyc - t0, m_axis_tdata);
        else n_pass++;
    endtask

    task automatic test_pattern();
        int t;
        int words;
        int t_word;
        int last_rise;
        logic prev_v;
        logic prev_m;
        mode = 1; alt_next = 1'b1;
        words = 0; t_word = -1; last_rise = -1; t = 0;
        prev_v = m_axis_tvalid; prev_m = mic_clk;
        while (words < 2 && t < 200) begin
            cyc(); t++;
            n_checks++;
            if ({m_axis_tvalid, m_axis_tdata, overflow, busy} !== {exp_valid, exp_data, exp_ovf, phase != 0})
                $display("FAIL pattern_cycle @%0d: got valid=%b data=%h ovf=%b busy=%b, expected valid=%b data=%h ovf=%b busy=%b",
                         ncyc, m_axis_tvalid, m_axis_tdata, overflow, busy, exp_valid, exp_data, exp_ovf, phase != 0);
            else n_pass++;
            if (!prev_m && mic_clk === 1'b1) begin
                if (last_rise >= 0) begin
                    n_checks++;
                    if (ncyc - last_rise !== 8)
                        $display("FAIL mic_clk_period @%0d: got %0d cycles, expected 8", ncyc, ncyc - last_rise);
                    else n_pass++;
                end
                last_rise = ncyc;
            end
            if (!prev_v && m_axis_tvalid === 1'b1) begin
                n_checks++;
                if (m_axis_tdata !== 8'hAA)
                    $display("FAIL pattern_word @%0d: got %h, expected aa", ncyc, m_axis_tdata);
                else n_pass++;
                if (t_word >= 0) begin
                    n_checks++;
                    if (ncyc - t_word !== 64)
                        $display("FAIL word_spacing: got %0d cycles, expected 64", ncyc - t_word);
                    else n_pass++;
                end
                t_word = ncyc; words++;
            end
            prev_v = m_axis_tvalid; prev_m = mic_clk;
        end
        if (words < 2) begin
            n_checks++;
            $display("FAIL pattern_timeout: got %0d words, expected 2", words);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        bit hit;
        mode = 2; t = 0; hit = 1'b0;
        while (!hit && t < 200) begin
            m_axis_tready = (pend && nbits == DW - 1 && exp_valid) ? 1'b1 : 1'b0;
            hit = m_axis_tready;
            cyc(); t++;
            n_checks++;
            if ({m_axis_tvalid, m_axis_tdata, overflow, busy} !== {exp_valid, exp_data, exp_ovf, phase != 0})
                $display("FAIL b2b_cycle @%0d: got valid=%b data=%h ovf=%b busy=%b, expected valid=%b data=%h ovf=%b busy=%b",
                         ncyc, m_axis_tvalid, m_axis_tdata, overflow, busy, exp_valid, exp_data, exp_ovf, phase != 0);
            else n_pass++;
        end
        n_checks++;
        if (!hit || overflow !== 1'b0 || m_axis_tvalid !== 1'b1)
            $display("FAIL b2b_load: got coincident=%0d ovf=%b valid=%b, expected coincident=1 ovf=0 valid=1",
                     hit, overflow, m_axis_tvalid);
        else n_pass++;
        m_axis_tready = 1'b1;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        m_axis_tready = 1'b0;
        held = exp_data;
        repeat (138) begin
            cyc();
            n_checks++;
            if ({m_axis_tvalid, m_axis_tdata, overflow, busy} !== {exp_valid, exp_data, exp_ovf, phase != 0}
                || m_axis_tdata !== held)
                $display("FAIL bp_cycle @%0d: got valid=%b data=%h ovf=%b, expected valid=%b data=%h (held %h) ovf=%b",
                         ncyc, m_axis_tvalid, m_axis_tdata, overflow, exp_valid, exp_data, held, exp_ovf);
            else n_pass++;
        end
        n_checks++;
        if (overflow !== 1'b1 || m_axis_tvalid !== 1'b1)
            $display("FAIL bp_overflow: got ovf=%b valid=%b, expected ovf=1 valid=1", overflow, m_axis_tvalid);
        else n_pass++;
        m_axis_tready = 1'b1;
        cyc();
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || exp_valid !== 1'b0 || overflow !== 1'b1)
            $display("FAIL bp_release: got valid=%b ovf=%b, expected valid=0 ovf=1", m_axis_tvalid, overflow);
        else n_pass++;
    endtask

    task automatic test_stop();
        int t;
        m_axis_tready = 1'b0; t = 0;
        while (!exp_valid && t < 100) begin
            cyc(); t++;
        end
        repeat (20) cyc();
        n_checks++;
        if ({m_axis_tvalid, m_axis_tdata, overflow, busy} !== {exp_valid, exp_data, exp_ovf, phase != 0} || t >= 100)
            $display("FAIL stop_pending: got valid=%b data=%h ovf=%b busy=%b, expected valid=%b data=%h ovf=%b busy=%b",
                     m_axis_tvalid, m_axis_tdata, overflow, busy, exp_valid, exp_data, exp_ovf, phase != 0);
        else n_pass++;
        enable = 1'b0;
        cyc();
        n_checks++;
        if (mic_clk !== 1'b0 || busy !== 1'b1 || m_axis_tvalid !== 1'b1)
            $display("FAIL stop_enter: got mclk=%b busy=%b valid=%b, expected mclk=0 busy=1 valid=1",
                     mic_clk, busy, m_axis_tvalid);
        else n_pass++;
        enable = 1'b1;
        repeat (2) cyc();
        enable = 1'b0;
        cyc();
        n_checks++;
        if ({m_axis_tvalid, m_axis_tdata, overflow, busy, mic_clk} !== {exp_valid, exp_data, exp_ovf, phase != 0, 1'b0}
            || phase != 2)
            $display("FAIL drain_hold @%0d: got valid=%b data=%h ovf=%b busy=%b mclk=%b, expected valid=1 data=%h ovf=%b busy=1 mclk=0",
                     ncyc, m_axis_tvalid, m_axis_tdata, overflow, busy, mic_clk, exp_data, exp_ovf);
        else n_pass++;
        m_axis_tready = 1'b1;
        cyc();
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b1)
            $display("FAIL drain_accept: got valid=%b busy=%b, expected valid=0 busy=1", m_axis_tvalid, busy);
        else n_pass++;
        cyc();
        n_checks++;
        if (busy !== 1'b0 || mic_clk !== 1'b0 || overflow !== exp_ovf)
            $display("FAIL drain_idle: got busy=%b mclk=%b ovf=%b, expected busy=0 mclk=0 ovf=%b",
                     busy, mic_clk, overflow, exp_ovf);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int t;
        m_axis_tready = 1'b0; mode = 2; enable = 1'b1;
        cyc();
        n_checks++;
        if (overflow !== 1'b0 || busy !== 1'b1)
            $display("FAIL restart_clear: got ovf=%b busy=%b, expected ovf=0 busy=1", overflow, busy);
        else n_pass++;
        t = 0;
        while (!exp_valid && t < 200) begin
            cyc(); t++;
            n_checks++;
            if ({m_axis_tvalid, m_axis_tdata, overflow, busy} !== {exp_valid, exp_data, exp_ovf, phase != 0})
                $display("FAIL rst_fill_cycle @%0d: got valid=%b data=%h ovf=%b busy=%b, expected valid=%b data=%h ovf=%b busy=%b",
                         ncyc, m_axis_tvalid, m_axis_tdata, overflow, busy, exp_valid, exp_data, exp_ovf, phase != 0);
            else n_pass++;
        end
        repeat (3) cyc();
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || t >= 200)
            $display("FAIL rst_precondition: got valid=%b, expected 1", m_axis_tvalid);
        else n_pass++;
        reset_n = 1'b0;
        cyc();
        n_checks++;
        if ({mic_clk, m_axis_tvalid, m_axis_tdata, overflow, busy} !== '0)
            $display("FAIL mid_reset: got mclk=%b valid=%b data=%h ovf=%b busy=%b, expected all 0",
                     mic_clk, m_axis_tvalid, m_axis_tdata, overflow, busy);
        else n_pass++;
        reset_n = 1'b1;
        cyc();
        n_checks++;
        if (busy !== 1'b1 || mic_clk !== 1'b0 || m_axis_tvalid !== 1'b0)
            $display("FAIL reset_restart: got busy=%b mclk=%b valid=%b, expected busy=1 mclk=0 valid=0",
                     busy, mic_clk, m_axis_tvalid);
        else n_pass++;
    endtask

    task automatic test_random_ready();
        mode = 2;
        repeat (600) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            cyc();
            n_checks++;
            if ({m_axis_tvalid, m_axis_tdata, overflow, busy} !== {exp_valid, exp_data, exp_ovf, phase != 0})
                $display("FAIL rand_cycle @%0d: got valid=%b data=%h ovf=%b busy=%b, expected valid=%b data=%h ovf=%b busy=%b",
                         ncyc, m_axis_tvalid, m_axis_tdata, overflow, busy, exp_valid, exp_data, exp_ovf, phase != 0);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_pattern();
        test_back_to_back();
        test_backpressure();
        test_stop();
        test_mid_reset();
        test_random_ready();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pdm_mic_ctrl.md
PDM_MIC_CTRL -- requirements
Module: pdm_mic_ctrl

Interface
REQ-001 SHALL have parameter INPUT_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter OUTPUT_FREQ, default 2400000, target mic clock frequency in Hz; CLK_DIVIDER = INPUT_FREQ/OUTPUT_FREQ, HALF = CLK_DIVIDER/2, and HALF SHALL be at least 2.
REQ-003 SHALL have parameter WARMUP_MIC_CLKS, default 24000, the number of mic clock rising edges discarded after enable.
REQ-004 SHALL have parameter DATA_WIDTH, default 16, the number of PDM bits packed per output word.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: level request to run capture.
REQ-008 SHALL have port mic_data, input, 1 bit: PDM data from the microphone.
REQ-009 SHALL have port mic_clk, output, 1 bit: microphone clock.
REQ-010 SHALL have port m_axis_tdata, output, DATA_WIDTH bits: packed PDM word, first bit in the MSB.
REQ-011 SHALL have ports m_axis_tvalid (output, 1 bit) and m_axis_tready (input, 1 bit): AXI-Stream handshake.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag for a dropped word.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, WARMUP, CAPTURE and DRAIN.
REQ-015 IDLE: the divider is held cleared and mic_clk is 0; when enable=1, the FSM SHALL enter WARMUP on the next clock, clear overflow, and clear the bit counter and warmup counter.
REQ-016 Divider: a counter runs 0..HALF-1 and toggles mic_clk at the wrap; a rise strobe SHALL pulse for one cycle, coincident with mic_clk going 0->1, and a fall strobe SHALL pulse for one cycle, coincident with mic_clk going 1->0.
REQ-017 The first mic_clk rising edge after entering WARMUP SHALL occur HALF cycles after entry, giving a mic_clk period of 2*HALF cycles.
REQ-018 WARMUP: the FSM SHALL count rise strobes, ignore mic_data, and enter CAPTURE on the cycle after rise strobe number WARMUP_MIC_CLKS.
REQ-019 CAPTURE: on each fall strobe, mic_data SHALL be shifted into the shift register LSB-side, so the first bit captured ends up in the MSB.
REQ-020 On the DATA_WIDTH-th bit, the completed word SHALL load into the output register with m_axis_tvalid=1 on the following cycle, and the bit counter SHALL wrap to 0.
REQ-021 A handshake SHALL complete only on a cycle where tvalid=1 and tready=1; tvalid SHALL clear on the next cycle unless a new word loads on that same cycle.
REQ-022 tdata SHALL be held stable while tvalid=1 and tready=0.
REQ-023 If a word completes while tvalid=1 and tready=0, the new word SHALL be dropped, the held word SHALL be kept, and overflow SHALL be set to 1.
REQ-024 If a word completes on the same cycle as a handshake, the new word SHALL load with no overflow.
REQ-025 When enable=0 in WARMUP or CAPTURE, the FSM SHALL enter DRAIN on the next cycle; mic_clk SHALL be forced to 0, the divider stopped, and any partial word discarded.
REQ-026 DRAIN: the FSM SHALL enter IDLE once tvalid=0; the pending word SHALL remain offered until accepted; enable=1 during DRAIN SHALL be ignored until IDLE is reached.
REQ-027 overflow SHALL remain set until reset or until the IDLE->WARMUP transition.

Reset
REQ-028 When reset_n=0 at a clock edge, all state SHALL return to IDLE on the next cycle from any state, including mid-word and mid-handshake: mic_clk=0, tvalid=0, tdata=0, overflow=0, busy=0, all counters 0.

Structure
REQ-029 The state enum type and a clog2-based width helper SHALL reside in the shared package pdm_pkg.
REQ-030 The divider and its strobes SHALL be a sub-module named pdm_clk_div, with ports clk, reset_n, run, mic_clk, rise and fall.

Verification
REQ-031 Parameters for all directed scenarios: INPUT_FREQ=8, OUTPUT_FREQ=1 (HALF=4), WARMUP_MIC_CLKS=4, DATA_WIDTH=8, tready=1 unless stated otherwise.
REQ-032 Startup: enable=1, mic_data=1 -> first mic_clk rise 4 cycles after busy; 4 warmup rises; first tvalid with tdata=0xFF.
REQ-033 Pattern: mic_data alternates 1,0 per fall strobe starting with 1 -> tdata=0xAA, with successive words 64 cycles apart.
REQ-034 Backpressure: tready=0 for 2 word periods -> first word held, overflow=1, and tdata unchanged until tready=1.
REQ-035 Stop: enable=0 mid-word with one pending word and tready=0 -> mic_clk=0 next cycle and FSM in DRAIN; tready=1 -> one handshake, then IDLE and busy=0.
REQ-036 Reset: reset_n=0 for one cycle during CAPTURE with tvalid=1 -> next cycle all outputs 0 and FSM IDLE; with enable still 1, the FSM restarts in WARMUP.
